adsr_axil_regs: RTL and testbench

- AXI4-Lite slave register file at the far end of the master bus that drives the ADSR envelope IP.
- Terminates AW/W/B/AR/R and holds the four envelope parameters (attack, decay, sustain, release), a control register and read-only status/version.
- Drives parameter and gate outputs into the ADSR envelope core.
- Responds to sequential 32-bit single-beat writes at 0x00..0x0C followed by read-back of the same data.

---
 rtl/adsr_axil_pkg.sv | 43 ++++
 rtl/adsr_axil_wchan.sv | 97 +++++++++
 rtl/adsr_axil_regs.sv | 182 ++++++++++++++++++
 tb/tb_adsr_axil_regs.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_axil_pkg.sv
// Shared definitions for the ADSR AXI4-Lite register block: register map, response codes, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package adsr_axil_pkg;

    // Word indices (byte address bits [4:2])
    localparam logic [2:0] REG_ATTACK  = 3'd0;
    localparam logic [2:0] REG_DECAY   = 3'd1;
    localparam logic [2:0] REG_SUSTAIN = 3'd2;
    localparam logic [2:0] REG_RELEASE = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_VERSION = 3'd6;
    localparam logic [2:0] REG_RSVD    = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // CTRL register bit positions
    localparam int CTRL_GATE_BIT   = 0;
    localparam int CTRL_COMMIT_BIT = 2;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // Only ATTACK..CTRL are writable; everything above is read-only or reserved.
    function automatic logic [1:0] wr_resp(input logic [2:0] idx);
        return (idx <= REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
    endfunction

    // Apply a write with per-byte strobes on top of the old register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/adsr_axil_wchan.sv
// AXI4-Lite write channel: independent AW/W holding regs, one outstanding write, emits a commit strobe.
// Latency: commit strobe on the edge that completes the AW+W pair; bvalid visible the following cycle.
// Backpressure: awready/wready low while their holding reg is full; both stay low until B handshakes.
module adsr_axil_wchan
    import adsr_axil_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wvalid,
    output logic            wready,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    output logic            commit_vld,
    output logic [AW-1:0]   commit_addr,
    output logic [DW-1:0]   commit_dat,
    output logic [DW/8-1:0] commit_strb
);

    wstate_t          state;
    logic             aw_full;
    logic             w_full;
    logic [AW-1:0]    aw_addr_q;
    logic [DW-1:0]    w_dat_q;
    logic [DW/8-1:0]  w_strb_q;

    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic w_have;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_have = aw_full || aw_hs;
    assign w_have  = w_full || w_hs;

    // Commit as soon as both halves are available, bypassing the holding regs
    // for whichever half arrives on this very edge.
    assign commit_vld  = (state == W_IDLE) && aw_have && w_have;
    assign commit_addr = aw_full ? aw_addr_q : awaddr;
    assign commit_dat  = w_full ? w_dat_q : wdata;
    assign commit_strb = w_full ? w_strb_q : wstrb;

    // Holding-register capture and write-response FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= W_IDLE;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else if (state == W_IDLE) begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_dat_q  <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit_vld) begin
                state   <= W_RESP;
                bvalid  <= 1'b1;
                bresp   <= wr_resp(commit_addr[AW-1:AW-3]);
                awready <= 1'b0;
                wready  <= 1'b0;
            end else begin
                awready <= !aw_have;
                wready  <= !w_have;
            end
        end else begin
            if (bready) begin
                state   <= W_IDLE;
                bvalid  <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                awready <= 1'b1;
                wready  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adsr_axil_regs.sv
// AXI4-Lite register file feeding the ADSR envelope core (params, gate, status, version); optional ADSR_AXIL_SHADOW_EN.
// Latency: write visible on outputs the cycle after commit (shadow build: one cycle later); read data one cycle after AR.
// Backpressure: one outstanding write and one outstanding read; ready signals drop until B/R handshake.
module adsr_axil_regs
    import adsr_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0002_0000
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   attack_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   decay_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   sustain_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   release_o,
    output logic                            gate_o,
    input  logic [2:0]                      env_stage_i,
    output logic                            param_upd_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic            commit_vld;
    logic [AW-1:0]   commit_addr;
    logic [DW-1:0]   commit_dat;
    logic [DW/8-1:0] commit_strb;

    logic [3:0][DW-1:0] param_q;
    logic [3:0][DW-1:0] param_out;
    logic               gate_q;

    logic [2:0]    wr_idx;
    logic          wr_is_param;
    logic [DW-1:0] wr_merged;

    rstate_t       rstate;
    logic [2:0]    rd_idx;
    logic [DW-1:0] rd_mux;

    logic unused_sig;
    assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0], commit_addr[1:0]};

    adsr_axil_wchan #(
        .AW (AW),
        .DW (DW)
    ) u_wchan (
        .clk         (s00_axi_aclk),
        .rst         (s00_axi_areset),
        .awaddr      (s00_axi_awaddr),
        .awvalid     (s00_axi_awvalid),
        .awready     (s00_axi_awready),
        .wdata       (s00_axi_wdata),
        .wstrb       (s00_axi_wstrb),
        .wvalid      (s00_axi_wvalid),
        .wready      (s00_axi_wready),
        .bresp       (s00_axi_bresp),
        .bvalid      (s00_axi_bvalid),
        .bready      (s00_axi_bready),
        .commit_vld  (commit_vld),
        .commit_addr (commit_addr),
        .commit_dat  (commit_dat),
        .commit_strb (commit_strb)
    );

    assign wr_idx      = commit_addr[AW-1:AW-3];
    assign wr_is_param = (wr_idx <= REG_RELEASE);
    assign wr_merged   = merge_bytes(param_q[wr_idx[1:0]], commit_dat, commit_strb);

    // Register storage: parameter regs (shadows in the shadow build) and the gate bit
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            param_q <= '0;
            gate_q  <= 1'b0;
        end else if (commit_vld) begin
            if (wr_is_param) param_q[wr_idx[1:0]] <= wr_merged;
            if (wr_idx == REG_CTRL && commit_strb[0]) gate_q <= commit_dat[CTRL_GATE_BIT];
        end
    end

`ifdef ADSR_AXIL_SHADOW_EN
    logic               commit_pend;
    logic [3:0][DW-1:0] out_q;

    // Shadow transfer: all four outputs move together one cycle after a CTRL commit write
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            commit_pend <= 1'b0;
            out_q       <= '0;
            param_upd_o <= 1'b0;
        end else begin
            commit_pend <= commit_vld && (wr_idx == REG_CTRL) && commit_strb[0]
                           && commit_dat[CTRL_COMMIT_BIT];
            param_upd_o <= 1'b0;
            if (commit_pend) begin
                out_q       <= param_q;
                param_upd_o <= (out_q != param_q);
            end
        end
    end

    assign param_out = out_q;
`else
    // Update pulse coincides with the first cycle the new parameter value is visible
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            param_upd_o <= 1'b0;
        end else begin
            param_upd_o <= commit_vld && wr_is_param && (wr_merged != param_q[wr_idx[1:0]]);
        end
    end

    assign param_out = param_q;
`endif

    assign attack_o  = param_out[0];
    assign decay_o   = param_out[1];
    assign sustain_o = param_out[2];
    assign release_o = param_out[3];
    assign gate_o    = gate_q;

    assign rd_idx = s00_axi_araddr[AW-1:AW-3];

    // Read mux over the register map
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_ATTACK, REG_DECAY, REG_SUSTAIN, REG_RELEASE: rd_mux = param_q[rd_idx[1:0]];
            REG_CTRL:    rd_mux = {{(DW-1){1'b0}}, gate_q};
            REG_STATUS:  rd_mux = {{(DW-3){1'b0}}, env_stage_i};
            REG_VERSION: rd_mux = VERSION;
            default:     rd_mux = '0;
        endcase
    end

    // Read FSM: sample on AR handshake, hold R stable until rready
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            rstate          <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else if (rstate == R_IDLE) begin
            s00_axi_arready <= 1'b1;
            if (s00_axi_arvalid && s00_axi_arready) begin
                rstate          <= R_DATA;
                s00_axi_arready <= 1'b0;
                s00_axi_rvalid  <= 1'b1;
                s00_axi_rdata   <= rd_mux;
                s00_axi_rresp   <= RESP_OKAY;
            end
        end else begin
            if (s00_axi_rready) begin
                rstate          <= R_IDLE;
                s00_axi_rvalid  <= 1'b0;
                s00_axi_arready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adsr_axil_regs.sv
// Self-checking bench for adsr_axil_regs: directed register-map cases plus randomized AXI traffic against a reference model.
// Latency: n/a.
// Backpressure: exercised via randomized and held bready/rready.
module tb_adsr_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] attack_o, decay_o, sustain_o, release_o;
    logic        gate_o;
    logic [2:0]  env_stage;
    logic        param_upd;

    always #5 clk = ~clk;

    adsr_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .attack_o        (attack_o),
        .decay_o         (decay_o),
        .sustain_o       (sustain_o),
        .release_o       (release_o),
        .gate_o          (gate_o),
        .env_stage_i     (env_stage),
        .param_upd_o     (param_upd)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [4];      // what a read of 0x00..0x0C must return
    logic [31:0] m_out [4];      // what attack_o..release_o must show
    logic [31:0] m_out_prev [4];
    logic        m_gate;
    bit          m_pend;
    bit          chk_en;
    bit          chg;
    logic        prev_bvalid;
    int          upd_cnt;
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    logic [3:0]  cur_s;
    logic [1:0]  last_bresp;
    logic [31:0] last_rdata;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = '0; m_out[i] = '0; m_out_prev[i] = '0;
        end
        m_gate = 1'b0; m_pend = 0; prev_bvalid = 1'b0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[4:2]);
        if (idx < 4) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) m_mem[idx][8*k +: 8] = d[8*k +: 8];
`ifndef ADSR_AXIL_SHADOW_EN
            m_out[idx] = m_mem[idx];
`endif
        end else if (idx == 4 && s[0]) begin
            m_gate = d[0];
`ifdef ADSR_AXIL_SHADOW_EN
            if (d[2]) m_pend = 1;
`endif
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return m_mem[a[3:2]];
            3'd4: return {31'b0, m_gate};
            3'd5: return {29'b0, env_stage};
            3'd6: return 32'h0002_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] model_bresp(input logic [4:0] a);
        return (a[4:2] <= 3'd4) ? 2'b00 : 2'b10;
    endfunction

    // Per-cycle comparison of the envelope-facing outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            m_out_prev = m_out;
            if (m_pend) begin
                m_out  = m_mem;
                m_pend = 0;
            end
            if (bvalid && !prev_bvalid) model_write(cur_a, cur_d, cur_s);
            prev_bvalid = bvalid;
            chg = 0;
            for (int i = 0; i < 4; i++) if (m_out[i] !== m_out_prev[i]) chg = 1;
            check("attack_o",  attack_o,  m_out[0]);
            check("decay_o",   decay_o,   m_out[1]);
            check("sustain_o", sustain_o, m_out[2]);
            check("release_o", release_o, m_out[3]);
            check("gate_o",    gate_o,    m_gate);
            check("param_upd", param_upd, chg);
            if (param_upd) upd_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_resp = model_bresp(a);
        cur_a = a; cur_d = d; cur_s = s;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 100) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (w_done && !aw_done) check("wready_held", wready, 0);
            if (aw_done && !w_done) check("awready_held", awready, 0);
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        check("aw_w_handshake", {aw_done, w_done}, 2'b11);
        check("b_latency", bvalid, 1);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("b_hold_valid", bvalid, 1);
            check("b_hold_resp", bresp, exp_resp);
            check("b_hold_awready", awready, 0);
            check("b_hold_wready", wready, 0);
            @(posedge clk); #1;
        end
        bready = 1;
        @(negedge clk);
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        last_bresp = bresp;
        @(posedge clk); #1;
        bready = 0;
        check("b_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [4:0] a, input int ar_dly, input int r_dly);
        logic [31:0] exp;
        bit hs;
        int cyc;
        hs = 0; cyc = 0; exp = '0;
        araddr = a;
        while (!hs && cyc < 100) begin
            arvalid = (cyc >= ar_dly);
            @(negedge clk);
            hs = arvalid && arready;
            if (hs) exp = model_read(a);
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
        check("ar_handshake", hs, 1);
        check("r_latency", rvalid, 1);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, exp);
            check("r_hold_arready", arready, 0);
            @(posedge clk); #1;
        end
        rready = 1;
        @(negedge clk);
        check("rdata", rdata, exp);
        check("rresp", rresp, 2'b00);
        last_rdata = rdata;
        @(posedge clk); #1;
        rready = 0;
        check("r_drop", rvalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; chk_en = 0; upd_cnt = 0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0; env_stage = 3'd0;
        last_bresp = '0; last_rdata = '0; cur_a = '0; cur_d = '0; cur_s = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_resps", {bresp, rresp}, 4'b0);
        check("rst_param_upd", param_upd, 0);
        check("rst_attack", attack_o, 0);
        check("rst_gate", gate_o, 0);
        @(posedge clk); #1;
        rst = 0; chk_en = 1;
        @(posedge clk); #1;

        // Sequential parameter writes and read-back
        upd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
            check("t1_bresp", last_bresp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4*i), 0, 0);
            check("t1_rdata", last_rdata, 32'(i + 1));
        end
`ifdef ADSR_AXIL_SHADOW_EN
        check("t1_upd_count", upd_cnt, 0);
        check("t1_attack", attack_o, 0);
`else
        check("t1_upd_count", upd_cnt, 4);
        check("t1_release", release_o, 32'h4);
`endif

        // W leads AW by three cycles
        axi_write(5'h04, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
        check("t2_bresp", last_bresp, 2'b00);
`ifndef ADSR_AXIL_SHADOW_EN
        check("t2_decay", decay_o, 32'hDEAD_BEEF);
`endif

        // Byte strobes
        axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(5'h08, 32'h0000_AB00, 4'b0010, 1, 0, 0);
        axi_read(5'h08, 0, 0);
        check("t3_strobe", last_rdata, 32'hFFFF_ABFF);
        axi_write(5'h08, 32'h1234_5678, 4'b0000, 0, 0, 0);
        check("t3_nostrb_bresp", last_bresp, 2'b00);

        // Read-only / reserved space
        axi_write(5'h18, 32'h1111_1111, 4'hF, 0, 0, 0);
        check("t4_slverr", last_bresp, 2'b10);
        axi_read(5'h18, 0, 0);
        check("t4_version", last_rdata, 32'h0002_0000);
        axi_read(5'h1C, 0, 0);
        check("t4_rsvd", last_rdata, 32'h0);
        env_stage = 3'd3;
        axi_read(5'h14, 0, 0);
        check("t4_status", last_rdata, 32'h3);

        // Backpressure on B and R
        axi_write(5'h0C, 32'hCAFE_0001, 4'hF, 0, 0, 10);
        axi_read(5'h0C, 0, 10);
        check("t5_rdata", last_rdata, 32'hCAFE_0001);

`ifdef ADSR_AXIL_SHADOW_EN
        upd_cnt = 0;
        axi_write(5'h00, 32'h10, 4'hF, 0, 0, 0);
        check("t6_attack_held", attack_o, 32'h0);
        axi_read(5'h00, 0, 0);
        check("t6_shadow_rd", last_rdata, 32'h10);
        axi_write(5'h10, 32'h4, 4'hF, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_attack_commit", attack_o, 32'h10);
        check("t6_upd_count", upd_cnt, 1);
`endif

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            env_stage = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                axi_write(5'($urandom_range(0, 31)), $urandom(), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset during outstanding B and R responses
        chk_en = 0;
        awaddr = 5'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 5'h00; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("t7_pre_bvalid", bvalid, 1);
        check("t7_pre_rvalid", rvalid, 1);
        #1 rst = 1;
        #1;
        check("t7_async_bvalid", bvalid, 0);
        check("t7_async_rvalid", rvalid, 0);
        check("t7_async_attack", attack_o, 0);
        @(posedge clk); #1;
        rst = 0;
        m_reset();
        bready = 1; rready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t7_no_bvalid", bvalid, 0);
            check("t7_no_rvalid", rvalid, 0);
        end
        @(posedge clk); #1;
        bready = 0; rready = 0;
        chk_en = 1;
        axi_write(5'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
        axi_read(5'h04, 0, 0);
        check("t7_recover", last_rdata, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
